// File: rtl/edge_det_multi_pkg.sv
// Package for edge_det_multi: per-channel mode encodings and a constant
// ceil-log2 helper used to size the debounce stability counter.
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // ceil(log2(v)), minimum 1 so a vector built from it is never zero-width
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/edge_det_multi_if.sv
// Bus bundle for edge_det_multi.
//   i_din    raw async inputs, one per channel
//   i_mode   2 bits per channel: [0] count rising, [1] count falling
//   i_clr    per-channel clear of sticky flag and counter
//   o_r_edge / o_f_edge  one-cycle edge pulses (mode independent)
//   o_event  one-cycle pulse for mode-selected edges
//   o_sticky latched event flag, o_any = OR of sticky flags
//   o_cnt    CNT_W-bit saturating event counter per channel
// master = driver of inputs (control side), slave = the detector.
interface edge_det_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       i_din;
  logic [2*N_CH-1:0]     i_mode;
  logic [N_CH-1:0]       i_clr;
  logic [N_CH-1:0]       o_r_edge;
  logic [N_CH-1:0]       o_f_edge;
  logic [N_CH-1:0]       o_event;
  logic [N_CH-1:0]       o_sticky;
  logic                  o_any;
  logic [N_CH*CNT_W-1:0] o_cnt;

  modport master (
    output i_din, i_mode, i_clr,
    input  o_r_edge, o_f_edge, o_event, o_sticky, o_any, o_cnt
  );

  modport slave (
    input  i_din, i_mode, i_clr,
    output o_r_edge, o_f_edge, o_event, o_sticky, o_any, o_cnt
  );
endinterface

// File: rtl/edge_det_multi_chan.sv
// One edge-detector channel: synchroniser, debounce filter, registered
// edge/event pulses, sticky flag and saturating event counter.
// Ports: i_clk, i_rstn (async low), i_din, i_mode[1:0], i_clr,
//        o_r_edge, o_f_edge, o_event, o_sticky, o_cnt[CNT_W-1:0].
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_din,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  output logic             o_r_edge,
  output logic             o_f_edge,
  output logic             o_event,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int STAB_W = clog2(DEBOUNCE + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic                   filt_q, filt_d;
  logic                   r_q, r_d, f_q, f_d, ev_q, ev_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_din};

    // stab counts consecutive clocks the synced level disagrees with filt
    filt_d = filt_q;
    stab_d = '0;
    if (sync_out != filt_q) begin
      if (stab_q == STAB_LAST) filt_d = sync_out;
      else                     stab_d = stab_q + STAB_W'(1);
    end

    // edges are taken from the filt transition happening on this clock,
    // so pulses appear in the cycle right after filt moves
    r_d  = filt_d & ~filt_q;
    f_d  = ~filt_d & filt_q;
    ev_d = (r_d & |(i_mode & MODE_RISE)) | (f_d & |(i_mode & MODE_FALL));

    // a coincident event beats the clear
    sticky_d = ev_q | (sticky_q & ~i_clr);

    cnt_d = cnt_q;
    if (ev_q) begin
      if (i_clr)                 cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (i_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q   <= '0;
      stab_q   <= '0;
      filt_q   <= 1'b0;
      r_q      <= 1'b0;
      f_q      <= 1'b0;
      ev_q     <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stab_q   <= stab_d;
      filt_q   <= filt_d;
      r_q      <= r_d;
      f_q      <= f_d;
      ev_q     <= ev_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_r_edge = r_q;
  assign o_f_edge = f_q;
  assign o_event  = ev_q;
  assign o_sticky = sticky_q;
  assign o_cnt    = cnt_q;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel debounced edge detector. Instantiates N_CH independent
// edge_det_chan channels; only o_any combines channel state.
// Ports: i_clk, i_rstn (async low), bus (edge_det_multi_if.slave).
module edge_det_multi
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  edge_det_multi_if.slave bus
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_din    (bus.i_din[k]),
      .i_mode   (bus.i_mode[2*k +: 2]),
      .i_clr    (bus.i_clr[k]),
      .o_r_edge (bus.o_r_edge[k]),
      .o_f_edge (bus.o_f_edge[k]),
      .o_event  (bus.o_event[k]),
      .o_sticky (bus.o_sticky[k]),
      .o_cnt    (bus.o_cnt[CNT_W*k +: CNT_W])
    );
  end

  assign bus.o_any = |bus.o_sticky;

endmodule

// File: tb/tb_edge_det_multi.sv
module tb_edge_det_multi;
  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;
  localparam int W = 3;
  localparam int CMAX = (1 << W) - 1;

  logic clk;
  logic rstn;
  int   tests = 0;
  int   fails = 0;

  edge_det_multi_if #(.N_CH(N), .CNT_W(W)) bus ();

  edge_det_multi #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(W)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: filt flips when the last D synchronised samples all
  // disagree with it; a synchronised sample is the raw input S clocks ago.
  bit m_filt[N];
  bit m_r[N];
  bit m_f[N];
  bit m_ev[N];
  bit m_sticky[N];
  int m_cnt[N];
  bit smp[N][$];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_filt[c] = 0; m_r[c] = 0; m_f[c] = 0; m_ev[c] = 0;
      m_sticky[c] = 0; m_cnt[c] = 0;
      smp[c].delete();
      for (int j = 0; j < S + D; j++) smp[c].push_back(1'b0);
    end
  endtask

  task automatic model_clock();
    for (int c = 0; c < N; c++) begin
      bit flip, nf;
      bit [1:0] md;
      int L;
      smp[c].push_back(bus.i_din[c]);
      if (smp[c].size() > 64) void'(smp[c].pop_front());
      L = smp[c].size();
      flip = 1;
      for (int k = 0; k < D; k++)
        if (smp[c][L-1-S-k] == m_filt[c]) flip = 0;
      if (m_ev[c]) begin
        m_sticky[c] = 1;
        m_cnt[c] = bus.i_clr[c] ? 1 : ((m_cnt[c] + 1 > CMAX) ? CMAX : m_cnt[c] + 1);
      end else if (bus.i_clr[c]) begin
        m_sticky[c] = 0;
        m_cnt[c] = 0;
      end
      nf = flip ? !m_filt[c] : m_filt[c];
      m_r[c] = nf & !m_filt[c];
      m_f[c] = !nf & m_filt[c];
      md = bus.i_mode[2*c +: 2];
      m_ev[c] = (m_r[c] & md[0]) | (m_f[c] & md[1]);
      m_filt[c] = nf;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0]   er, ef, ee, es;
    logic [N*W-1:0] ec;
    for (int c = 0; c < N; c++) begin
      er[c] = m_r[c]; ef[c] = m_f[c]; ee[c] = m_ev[c]; es[c] = m_sticky[c];
      ec[W*c +: W] = W'(m_cnt[c]);
    end
    chk("r_edge", 32'(bus.o_r_edge), 32'(er));
    chk("f_edge", 32'(bus.o_f_edge), 32'(ef));
    chk("event",  32'(bus.o_event),  32'(ee));
    chk("sticky", 32'(bus.o_sticky), 32'(es));
    chk("any",    32'(bus.o_any),    32'(|es));
    chk("cnt",    32'(bus.o_cnt),    32'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_clock();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pulses;
    bit seen;

    // ---- reset state, ch0 held high through reset ----
    rstn = 1'b0;
    bus.i_din  = 4'b0001;
    bus.i_mode = {2'b11, 2'b10, 2'b01, 2'b01};
    bus.i_clr  = '0;
    model_reset();
    #12;
    check_all();
    steps(2);
    rstn = 1'b1;

    // ---- power-up edge: 6 clocks after release ----
    steps(5);
    chk("pwr_no_early_edge", 32'(bus.o_r_edge), 32'h0);
    step();
    chk("pwr_r_edge", 32'(bus.o_r_edge), 32'h1);
    chk("pwr_event",  32'(bus.o_event),  32'h1);
    step();
    chk("pwr_cnt0",   32'(bus.o_cnt[W-1:0]), 32'h1);
    chk("pwr_sticky", 32'(bus.o_sticky), 32'h1);
    chk("pwr_any",    32'(bus.o_any),    32'h1);

    // ---- glitch rejection on ch1 ----
    pulses = 0;
    bus.i_din[1] = 1'b1;
    steps(3);
    bus.i_din[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); pulses += int'(bus.o_r_edge[1]); end
    chk("glitch_no_edge", 32'(pulses), 32'h0);
    bus.i_din[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); pulses += int'(bus.o_r_edge[1]); end
    bus.i_din[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); pulses += int'(bus.o_r_edge[1]); end
    chk("glitch_one_edge", 32'(pulses), 32'h1);

    // ---- mode selection on ch2 ----
    bus.i_din[2] = 1'b1; steps(20);
    bus.i_din[2] = 1'b0; steps(20);
    chk("mode_fall_cnt", 32'(bus.o_cnt[2*W +: W]), 32'h1);
    bus.i_clr[2] = 1'b1; step(); bus.i_clr[2] = 1'b0;
    bus.i_mode[5:4] = 2'b11;
    bus.i_din[2] = 1'b1; steps(20);
    bus.i_din[2] = 1'b0; steps(20);
    bus.i_din[2] = 1'b1; steps(20);
    chk("mode_both_cnt", 32'(bus.o_cnt[2*W +: W]), 32'h3);
    bus.i_mode[5:4] = 2'b00;
    pulses = 0;
    bus.i_din[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); pulses += int'(bus.o_event[2]); end
    chk("mode_off_no_event", 32'(pulses), 32'h0);

    // ---- clear collisions on ch3 (mode 11) ----
    bus.i_din[3] = 1'b1; steps(20);
    chk("clr_pre_cnt", 32'(bus.o_cnt[3*W +: W]), 32'h1);
    bus.i_din[3] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = bus.o_event[3]; end
    chk("clr_event_seen", 32'(seen), 32'h1);
    bus.i_clr[3] = 1'b1; step(); bus.i_clr[3] = 1'b0;
    chk("clr_coll_sticky", 32'(bus.o_sticky[3]), 32'h1);
    chk("clr_coll_cnt", 32'(bus.o_cnt[3*W +: W]), 32'h1);
    bus.i_clr[3] = 1'b1; step(); bus.i_clr[3] = 1'b0;
    chk("clr_alone_sticky", 32'(bus.o_sticky[3]), 32'h0);
    chk("clr_alone_cnt", 32'(bus.o_cnt[3*W +: W]), 32'h0);

    // ---- saturation on ch0: 10 rising edges into a 3-bit counter ----
    for (int e = 0; e < 10; e++) begin
      bus.i_din[0] = 1'b0; steps(8);
      bus.i_din[0] = 1'b1; steps(8);
    end
    chk("sat_cnt0", 32'(bus.o_cnt[W-1:0]), 32'(CMAX));

    // ---- randomized traffic ----
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5) == 0) bus.i_din[c] = ~bus.i_din[c];
        bus.i_clr[c] = ($urandom_range(19) == 0);
      end
      if (t % 37 == 0) bus.i_mode = 8'($urandom);
      step();
    end
    bus.i_clr = '0;

    // ---- mid-operation reset during a debounce window ----
    bus.i_din = 4'b0000; steps(20);
    bus.i_din = 4'b1111; steps(4);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_any", 32'(bus.o_any), 32'h0);
    chk("rst_cnt", 32'(bus.o_cnt), 32'h0);
    #1 rstn = 1'b1;
    steps(5);
    chk("rst_no_early_edge", 32'(bus.o_r_edge), 32'h0);
    step();
    chk("rst_r_edge_full_latency", 32'(bus.o_r_edge), 32'hf);
    steps(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
